ex_mem_stage_reg: RTL and testbench

- Parametrised EX→MEM pipeline stage register. Replaces the fixed-width, always-advancing stage with a valid/ready handshake and a synchronous flush.
- Optional 2-entry skid buffer, so `in_ready` comes straight from a flop and a MEM-side stall does not combinationally reach EX.
- Sits between the ALU/EX stage and the data-memory stage.

---
 rtl/ex_mem_stage_reg.sv | 127 ++++++++++++
 tb/tb_ex_mem_stage_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline stage register with valid/ready handshake and synchronous flush.
// With SKID_EN=1 a second entry absorbs one beat so in_ready is driven from a flop.
module ex_mem_stage_reg #(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 8,
   parameter int RD_W    = 2,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_write_data,
   input  logic [RD_W-1:0]   ex_rd,
   input  logic [PC_W-1:0]   ex_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              mem_reg_write,
   output logic              mem_mem_read,
   output logic              mem_mem_write,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_write_data,
   output logic [RD_W-1:0]   mem_rd,
   output logic [PC_W-1:0]   mem_pc,
   output logic [1:0]        occupancy
);

   localparam int PAY_W = 3 + 2 * DATA_W + RD_W + PC_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PAY_W-1:0]   main_q, main_d;
   logic [PAY_W-1:0]   skid_q, skid_d;
   logic [PAY_W-1:0]   in_pay;
   logic               in_fire, out_fire;
   logic               main_reg_write, main_mem_read, main_mem_write;

   assign in_pay   = {ex_reg_write, ex_mem_read, ex_mem_write,
                      ex_alu_result, ex_write_data, ex_rd, ex_pc};
   assign out_valid = (state_q != EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   generate
      if (SKID_EN) begin : g_skid
         // Registered ready: MEM-side stalls reach EX only one cycle later, the skid entry covers the gap.
         logic in_ready_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               in_ready_q <= 1'b0;
            end else begin
               in_ready_q <= (state_d != SKID);
            end
         end
         assign in_ready = in_ready_q;
      end else begin : g_noskid
         assign in_ready = out_ready | ~out_valid;
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = FULL;
                  main_d  = in_pay;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_pay;
               end else if (in_fire) begin
                  state_d = SKID;
                  skid_d  = in_pay;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state_d = FULL;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign {main_reg_write, main_mem_read, main_mem_write,
           mem_alu_result, mem_write_data, mem_rd, mem_pc} = main_q;

   // Data fields stay visible while invalid; only the control bits are gated.
   assign mem_reg_write = main_reg_write & out_valid;
   assign mem_mem_read  = main_mem_read  & out_valid;
   assign mem_mem_write = main_mem_write & out_valid;
   assign occupancy     = state_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Self-checking bench: a skid and a no-skid instance share stimulus and are checked
// against per-instance FIFO scoreboards; a wide instance checks bit-exact pass-through.
module tb_ex_mem_stage_reg;

   typedef struct packed {
      logic       rw;
      logic       mr;
      logic       mw;
      logic [7:0] alu;
      logic [7:0] wd;
      logic [1:0] rd;
      logic [7:0] pc;
   } pay_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, flush, inValid, outReady;
   logic       exRegWrite, exMemRead, exMemWrite;
   logic [7:0] exAluResult, exWriteData, exPc;
   logic [1:0] exRd;

   logic       aInReady, aOutValid, aRw, aMr, aMw;
   logic [7:0] aAlu, aWd, aPc;
   logic [1:0] aRd, aOcc;
   logic       bInReady, bOutValid, bRw, bMr, bMw;
   logic [7:0] bAlu, bWd, bPc;
   logic [1:0] bRd, bOcc;

   logic        wFlush, wInValid, wInReady, wOutValid, wOutReady;
   logic        wExRw, wExMr, wExMw, wRw, wMr, wMw;
   logic [31:0] wExAlu, wExWd, wAlu, wWd;
   logic [4:0]  wExRd, wRd;
   logic [15:0] wExPc, wPc;
   logic [1:0]  wOcc;

   pay_t sbA[$];
   pay_t sbB[$];
   int   testCount = 0;
   int   failCount = 0;

   ex_mem_stage_reg #(.DATA_W(8), .PC_W(8), .RD_W(2), .SKID_EN(1'b1)) dutA (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(inValid), .in_ready(aInReady),
      .ex_reg_write(exRegWrite), .ex_mem_read(exMemRead), .ex_mem_write(exMemWrite),
      .ex_alu_result(exAluResult), .ex_write_data(exWriteData), .ex_rd(exRd), .ex_pc(exPc),
      .out_valid(aOutValid), .out_ready(outReady),
      .mem_reg_write(aRw), .mem_mem_read(aMr), .mem_mem_write(aMw),
      .mem_alu_result(aAlu), .mem_write_data(aWd), .mem_rd(aRd), .mem_pc(aPc),
      .occupancy(aOcc)
   );

   ex_mem_stage_reg #(.DATA_W(8), .PC_W(8), .RD_W(2), .SKID_EN(1'b0)) dutB (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(inValid), .in_ready(bInReady),
      .ex_reg_write(exRegWrite), .ex_mem_read(exMemRead), .ex_mem_write(exMemWrite),
      .ex_alu_result(exAluResult), .ex_write_data(exWriteData), .ex_rd(exRd), .ex_pc(exPc),
      .out_valid(bOutValid), .out_ready(outReady),
      .mem_reg_write(bRw), .mem_mem_read(bMr), .mem_mem_write(bMw),
      .mem_alu_result(bAlu), .mem_write_data(bWd), .mem_rd(bRd), .mem_pc(bPc),
      .occupancy(bOcc)
   );

   ex_mem_stage_reg #(.DATA_W(32), .PC_W(16), .RD_W(5), .SKID_EN(1'b1)) dutW (
      .clk(clk), .rst_n(rst_n), .flush(wFlush), .in_valid(wInValid), .in_ready(wInReady),
      .ex_reg_write(wExRw), .ex_mem_read(wExMr), .ex_mem_write(wExMw),
      .ex_alu_result(wExAlu), .ex_write_data(wExWd), .ex_rd(wExRd), .ex_pc(wExPc),
      .out_valid(wOutValid), .out_ready(wOutReady),
      .mem_reg_write(wRw), .mem_mem_read(wMr), .mem_mem_write(wMw),
      .mem_alu_result(wAlu), .mem_write_data(wWd), .mem_rd(wRd), .mem_pc(wPc),
      .occupancy(wOcc)
   );

   // Single point where every comparison is counted and mismatches reported.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Compares one instance's visible outputs against the head of its scoreboard.
   task automatic checkSide(input string s, input int sz, input pay_t f, input logic expRdy,
                            input logic rdy, input logic ov, input logic rw, input logic mr,
                            input logic mw, input logic [7:0] alu, input logic [7:0] wd,
                            input logic [7:0] pc, input logic [1:0] rd, input logic [1:0] occ);
      checkOutput({s, ".in_ready"}, 32'(rdy), 32'(expRdy));
      checkOutput({s, ".out_valid"}, 32'(ov), 32'(sz > 0));
      checkOutput({s, ".occupancy"}, 32'(occ), 32'(sz));
      if (sz > 0) begin
         checkOutput({s, ".mem_pc"}, 32'(pc), 32'(f.pc));
         checkOutput({s, ".mem_alu_result"}, 32'(alu), 32'(f.alu));
         checkOutput({s, ".mem_write_data"}, 32'(wd), 32'(f.wd));
         checkOutput({s, ".mem_rd"}, 32'(rd), 32'(f.rd));
         checkOutput({s, ".ctl"}, 32'({rw, mr, mw}), 32'({f.rw, f.mr, f.mw}));
      end else begin
         checkOutput({s, ".ctl_gated"}, 32'({rw, mr, mw}), 32'(0));
      end
   endtask

   // Reset must clear every output, payload included.
   task automatic checkCleared(input string s, input logic ov, input logic rw, input logic mr,
                               input logic mw, input logic [7:0] alu, input logic [7:0] wd,
                               input logic [7:0] pc, input logic [1:0] rd, input logic [1:0] occ);
      checkOutput({s, ".rst_out_valid"}, 32'(ov), 32'(0));
      checkOutput({s, ".rst_occupancy"}, 32'(occ), 32'(0));
      checkOutput({s, ".rst_ctl"}, 32'({rw, mr, mw}), 32'(0));
      checkOutput({s, ".rst_payload"}, {alu, wd, pc, 6'(rd), 2'b00}, 32'(0));
   endtask

   // Check current outputs, then advance one clock and update the scoreboards.
   task automatic stepCycle();
      logic aRdyExp, bRdyExp, aIn, bIn, aOut, bOut;
      pay_t inP, fA, fB;
      #1;
      inP     = {exRegWrite, exMemRead, exMemWrite, exAluResult, exWriteData, exRd, exPc};
      aRdyExp = (sbA.size() < 2);
      bRdyExp = (sbB.size() == 0) || outReady;
      fA      = (sbA.size() > 0) ? sbA[0] : '0;
      fB      = (sbB.size() > 0) ? sbB[0] : '0;
      checkSide("A", sbA.size(), fA, aRdyExp, aInReady, aOutValid, aRw, aMr, aMw,
                aAlu, aWd, aPc, aRd, aOcc);
      checkSide("B", sbB.size(), fB, bRdyExp, bInReady, bOutValid, bRw, bMr, bMw,
                bAlu, bWd, bPc, bRd, bOcc);
      aIn  = inValid & aRdyExp;
      bIn  = inValid & bRdyExp;
      aOut = (sbA.size() > 0) & outReady;
      bOut = (sbB.size() > 0) & outReady;
      @(posedge clk);
      if (aOut) void'(sbA.pop_front());
      if (bOut) void'(sbB.pop_front());
      if (flush) begin
         sbA.delete();
         sbB.delete();
      end else begin
         if (aIn) sbA.push_back(inP);
         if (bIn) sbB.push_back(inP);
      end
      @(negedge clk);
   endtask

   // Drive one cycle of shared stimulus; write data and rd are derived from alu/pc.
   task automatic applyStimulus(input logic v, input logic ordy, input logic fl,
                                input logic [2:0] ctl, input logic [7:0] alu, input logic [7:0] pc);
      inValid     = v;
      outReady    = ordy;
      flush       = fl;
      {exRegWrite, exMemRead, exMemWrite} = ctl;
      exAluResult = alu;
      exWriteData = alu ^ pc;
      exRd        = pc[1:0];
      exPc        = pc;
      stepCycle();
   endtask

   task automatic idleInputs();
      inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
      exRegWrite = 1'b0; exMemRead = 1'b0; exMemWrite = 1'b0;
      exAluResult = '0; exWriteData = '0; exRd = '0; exPc = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      idleInputs();
      wFlush = 1'b0; wInValid = 1'b0; wOutReady = 1'b0;
      wExRw = 1'b0; wExMr = 1'b0; wExMw = 1'b0;
      wExAlu = '0; wExWd = '0; wExRd = '0; wExPc = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkCleared("A", aOutValid, aRw, aMr, aMw, aAlu, aWd, aPc, aRd, aOcc);
      checkCleared("B", bOutValid, bRw, bMr, bMw, bAlu, bWd, bPc, bRd, bOcc);
      checkOutput("W.rst_out_valid", 32'(wOutValid), 32'(0));
      checkOutput("W.rst_alu", wAlu, 32'(0));
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);

      // Wide instance: bit-exact pass-through with one cycle of latency.
      wInValid = 1'b1; wOutReady = 1'b1;
      wExRw = 1'b1; wExMr = 1'b0; wExMw = 1'b1;
      wExAlu = 32'hDEADBEEF; wExWd = 32'h12345678; wExRd = 5'd31; wExPc = 16'hABCD;
      #1 checkOutput("W.in_ready", 32'(wInReady), 32'(1));
      @(posedge clk);
      @(negedge clk);
      wInValid = 1'b0;
      #1;
      checkOutput("W.out_valid", 32'(wOutValid), 32'(1));
      checkOutput("W.mem_alu_result", wAlu, 32'hDEADBEEF);
      checkOutput("W.mem_write_data", wWd, 32'h12345678);
      checkOutput("W.mem_rd", 32'(wRd), 32'd31);
      checkOutput("W.mem_pc", 32'(wPc), 32'hABCD);
      checkOutput("W.ctl", 32'({wRw, wMr, wMw}), 32'b101);
      checkOutput("W.occupancy", 32'(wOcc), 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("W.drained_valid", 32'(wOutValid), 32'(0));
      checkOutput("W.drained_ctl", 32'({wRw, wMr, wMw}), 32'(0));
      checkOutput("W.held_alu", wAlu, 32'hDEADBEEF);
      @(negedge clk);

      // Streaming with out_ready held high.
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b100, 8'h01, 8'h01);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 8'h02, 8'h02);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b001, 8'h03, 8'h03);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);

      // Backpressure fills the skid entry; the no-skid copy stalls EX instead.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b100, 8'hA0, 8'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b100, 8'hA1, 8'h11);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b100, 8'hA2, 8'h12);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 8'hA3, 8'h13);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);

      // Flush while two entries are held, with a competing input that must vanish.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b101, 8'h30, 8'h30);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b101, 8'h31, 8'h31);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'b101, 8'h20, 8'h20);
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);

      // Flush coinciding with a consumed output.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b110, 8'h50, 8'h50);
      applyStimulus(1'b1, 1'b1, 1'b1, 3'b110, 8'h51, 8'h51);
      applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);

      // Randomised traffic with occasional flush.
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                       8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);

      // Asynchronous reset between edges while the skid entry is occupied.
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 8'h40, 8'h40);
      applyStimulus(1'b1, 1'b0, 1'b0, 3'b111, 8'h41, 8'h41);
      checkOutput("A.pre_reset_occupancy", 32'(aOcc), 32'd2);
      idleInputs();
      #2 rst_n = 1'b0;
      #1;
      checkCleared("A", aOutValid, aRw, aMr, aMw, aAlu, aWd, aPc, aRd, aOcc);
      checkCleared("B", bOutValid, bRw, bMr, bMw, bAlu, bWd, bPc, bRd, bOcc);
      sbA.delete();
      sbB.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'b100, 8'h61, 8'h61);
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 8'h00, 8'h00);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
